// File: rtl/ipm2l_hsstlp_rst_lane_seq_v1_0_if.sv
// rtl/ipm2l_hsstlp_rst_lane_seq_v1_0_if.sv - lane reset sequencer control/status bundle
interface ipm2l_hsstlp_rst_lane_seq_v1_0_if;
  logic       lane_en;
  logic       pll_lock;
  logic       sigdet;
  logic       cdr_lock;
  logic       soft_rst;
  logic       lane_pma_rst;
  logic       lane_pcs_rst;
  logic       lane_ready;
  logic [2:0] seq_st;
  logic [2:0] retry_cnt;
  logic       timeout_err;

  // master: PLL-level reset logic / watchdog side; slave: the lane sequencer
  modport master (
    output lane_en, pll_lock, sigdet, cdr_lock, soft_rst,
    input  lane_pma_rst, lane_pcs_rst, lane_ready, seq_st, retry_cnt, timeout_err
  );

  modport slave (
    input  lane_en, pll_lock, sigdet, cdr_lock, soft_rst,
    output lane_pma_rst, lane_pcs_rst, lane_ready, seq_st, retry_cnt, timeout_err
  );
endinterface

// File: rtl/ipm2l_hsstlp_rst_lane_seq_v1_0.sv
// rtl/ipm2l_hsstlp_rst_lane_seq_v1_0.sv - per-lane HSST PMA/CDR/PCS reset sequencer
module ipm2l_hsstlp_rst_lane_seq_v1_0 #(
  parameter int PMA_RST_CYC     = 32,
  parameter int LOCK_STABLE_CYC = 64,
  parameter int PCS_RST_CYC     = 16,
  parameter int WAIT_CNTR_WIDTH = 16,
  parameter int MAX_RETRY       = 3
) (
  input logic clk,
  input logic rst_n,
  ipm2l_hsstlp_rst_lane_seq_v1_0_if.slave lane_if
);

  localparam int PH_MAX = (PMA_RST_CYC > PCS_RST_CYC) ? PMA_RST_CYC : PCS_RST_CYC;
  localparam int PH_W   = $clog2(PH_MAX + 1);
  localparam int ST_W   = $clog2(LOCK_STABLE_CYC + 1);

  localparam logic [PH_W-1:0] PMA_LAST  = PH_W'(PMA_RST_CYC - 1);
  localparam logic [PH_W-1:0] PCS_LAST  = PH_W'(PCS_RST_CYC - 1);
  localparam logic [ST_W-1:0] STAB_LAST = ST_W'(LOCK_STABLE_CYC - 1);
  localparam logic [2:0]      RETRY_MAX = 3'(MAX_RETRY);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PMA_RST  = 3'd1,
    ST_WAIT_CDR = 3'd2,
    ST_PCS_RST  = 3'd3,
    ST_DONE     = 3'd4,
    ST_FAIL     = 3'd5
  } state_t;

  state_t                     state_q, state_d;
  logic [PH_W-1:0]            phase_q, phase_d;
  logic [WAIT_CNTR_WIDTH-1:0] wait_q, wait_d, wait_inc;
  logic [ST_W-1:0]            stab_q, stab_d;
  logic [2:0]                 retry_q, retry_d;
  logic                       terr_q, terr_d;
  logic                       pma_q, pcs_q, ready_q;
  logic                       locked;
  logic                       timeout;

  assign locked   = lane_if.sigdet & lane_if.cdr_lock;
  // wait_inc is the number of cycles spent in WAIT_CDR including this one
  assign wait_inc = wait_q + 1'b1;
  assign timeout  = &wait_inc;

  always_comb begin
    state_d = state_q;
    phase_d = '0;
    wait_d  = '0;
    stab_d  = '0;
    retry_d = retry_q;
    terr_d  = terr_q;
    if (lane_if.soft_rst) begin
      state_d = ST_IDLE;
      retry_d = '0;
      terr_d  = 1'b0;
    end else if (state_q == ST_FAIL) begin
      if (!lane_if.lane_en) begin
        state_d = ST_IDLE;
        retry_d = '0;
      end
    end else if (!lane_if.lane_en || !lane_if.pll_lock) begin
      state_d = ST_IDLE;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PMA_RST;
        ST_PMA_RST: begin
          if (phase_q == PMA_LAST) state_d = ST_WAIT_CDR;
          else                     phase_d = phase_q + 1'b1;
        end
        ST_WAIT_CDR: begin
          wait_d = wait_inc;
          if (locked) stab_d = stab_q + 1'b1;
          // a lock that completes on the timeout cycle still counts as success
          if (locked && (stab_q == STAB_LAST)) begin
            state_d = ST_PCS_RST;
          end else if (timeout) begin
            if ((retry_q + 3'd1) == RETRY_MAX) begin
              state_d = ST_FAIL;
              retry_d = RETRY_MAX;
              terr_d  = 1'b1;
            end else begin
              state_d = ST_PMA_RST;
              retry_d = retry_q + 3'd1;
            end
          end
        end
        ST_PCS_RST: begin
          if (!locked)                  state_d = ST_PMA_RST;
          else if (phase_q == PCS_LAST) state_d = ST_DONE;
          else                          phase_d = phase_q + 1'b1;
        end
        ST_DONE: if (!locked) state_d = ST_PMA_RST;
        default: state_d = ST_IDLE;
      endcase
    end
    if (state_d != state_q) begin
      phase_d = '0;
      wait_d  = '0;
      stab_d  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      wait_q  <= '0;
      stab_q  <= '0;
      retry_q <= '0;
      terr_q  <= 1'b0;
      pma_q   <= 1'b1;
      pcs_q   <= 1'b1;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      wait_q  <= wait_d;
      stab_q  <= stab_d;
      retry_q <= retry_d;
      terr_q  <= terr_d;
      pma_q   <= (state_d == ST_IDLE) || (state_d == ST_PMA_RST) || (state_d == ST_FAIL);
      pcs_q   <= (state_d != ST_DONE);
      ready_q <= (state_d == ST_DONE);
    end
  end

  assign lane_if.lane_pma_rst = pma_q;
  assign lane_if.lane_pcs_rst = pcs_q;
  assign lane_if.lane_ready   = ready_q;
  assign lane_if.seq_st       = state_q;
  assign lane_if.retry_cnt    = retry_q;
  assign lane_if.timeout_err  = terr_q;

endmodule

// File: tb/tb_ipm2l_hsstlp_rst_lane_seq_v1_0.sv
// tb/tb_ipm2l_hsstlp_rst_lane_seq_v1_0.sv - scoreboard bench for the lane reset sequencer
module tb_ipm2l_hsstlp_rst_lane_seq_v1_0;
  localparam int PMA_RST_CYC     = 4;
  localparam int LOCK_STABLE_CYC = 8;
  localparam int PCS_RST_CYC     = 4;
  localparam int WAIT_CNTR_WIDTH = 6;
  localparam int MAX_RETRY       = 2;
  localparam int TIMEOUT_CYC     = (1 << WAIT_CNTR_WIDTH) - 1;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  ipm2l_hsstlp_rst_lane_seq_v1_0_if lif();

  ipm2l_hsstlp_rst_lane_seq_v1_0 #(
    .PMA_RST_CYC    (PMA_RST_CYC),
    .LOCK_STABLE_CYC(LOCK_STABLE_CYC),
    .PCS_RST_CYC    (PCS_RST_CYC),
    .WAIT_CNTR_WIDTH(WAIT_CNTR_WIDTH),
    .MAX_RETRY      (MAX_RETRY)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lane_if(lif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model state
  int m_st, m_cyc, m_clean, m_retry;
  bit m_terr;
  logic [9:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9:0] dut_outs();
    return {lif.seq_st, lif.lane_pma_rst, lif.lane_pcs_rst, lif.lane_ready,
            lif.retry_cnt, lif.timeout_err};
  endfunction

  function automatic logic [9:0] model_outs();
    logic pma, pcs, rdy;
    pma = (m_st == 0) || (m_st == 1) || (m_st == 5);
    pcs = (m_st != 4);
    rdy = (m_st == 4);
    return {3'(m_st), pma, pcs, rdy, 3'(m_retry), m_terr};
  endfunction

  task automatic model_reset();
    m_st = 0; m_cyc = 0; m_clean = 0; m_retry = 0; m_terr = 1'b0;
  endtask

  task automatic model_step();
    int  nxt;
    bit  lk;
    lk  = lif.sigdet & lif.cdr_lock;
    nxt = m_st;
    if (lif.soft_rst) begin
      nxt = 0; m_retry = 0; m_terr = 1'b0;
    end else if (m_st == 5) begin
      if (!lif.lane_en) begin nxt = 0; m_retry = 0; end
    end else if (!lif.lane_en || !lif.pll_lock) begin
      nxt = 0; m_retry = 0;
    end else begin
      case (m_st)
        0: nxt = 1;
        1: if (m_cyc + 1 == PMA_RST_CYC) nxt = 2;
        2: begin
          if (lk && (m_clean + 1 == LOCK_STABLE_CYC)) nxt = 3;
          else if (m_cyc + 1 == TIMEOUT_CYC) begin
            if (m_retry + 1 == MAX_RETRY) begin
              nxt = 5; m_retry = MAX_RETRY; m_terr = 1'b1;
            end else begin
              nxt = 1; m_retry = m_retry + 1;
            end
          end
        end
        3: if (!lk) nxt = 1; else if (m_cyc + 1 == PCS_RST_CYC) nxt = 4;
        4: if (!lk) nxt = 1;
        default: nxt = 0;
      endcase
    end
    if (nxt != m_st) begin
      m_cyc = 0; m_clean = 0;
    end else begin
      m_cyc++;
      m_clean = lk ? m_clean + 1 : 0;
    end
    m_st = nxt;
  endtask

  // one clock: predict, push, let the edge happen, pop and compare
  task automatic step();
    logic [9:0] e;
    model_step();
    exp_q.push_back(model_outs());
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_eq("outs", {22'd0, dut_outs()}, {22'd0, e});
  endtask

  task automatic run_until(input string tag, input int target, input int budget, output int n);
    n = 0;
    while (n < budget) begin
      step();
      n++;
      if (lif.seq_st == 3'(target)) break;
    end
    if (lif.seq_st != 3'(target)) check_eq(tag, {29'd0, lif.seq_st}, target);
  endtask

  initial begin
    int n;
    n_checks = 0;
    n_fail   = 0;
    lif.lane_en = 1'b1; lif.pll_lock = 1'b1; lif.sigdet = 1'b1;
    lif.cdr_lock = 1'b1; lif.soft_rst = 1'b0;
    rst_n = 1'b1;
    model_reset();
    #1 rst_n = 1'b0;
    #1 check_eq("reset_outs", {22'd0, dut_outs()}, {22'd0, 10'b000_1_1_0_000_0});
    @(posedge clk); @(posedge clk); #1;
    check_eq("reset_hold", {22'd0, dut_outs()}, {22'd0, 10'b000_1_1_0_000_0});
    rst_n = 1'b1;

    // nominal bring-up
    run_until("reach_pma", 1, 10, n);  check_eq("idle_to_pma", n, 1);
    run_until("reach_wait", 2, 20, n); check_eq("pma_len", n, PMA_RST_CYC);
    run_until("reach_pcs", 3, 100, n); check_eq("lock_len", n, LOCK_STABLE_CYC);
    run_until("reach_done", 4, 20, n); check_eq("pcs_len", n, PCS_RST_CYC);
    check_eq("ready_done", {31'd0, lif.lane_ready}, 1);

    // loss of CDR lock in DONE, then loss of PLL lock
    lif.cdr_lock = 1'b0; step(); lif.cdr_lock = 1'b1;
    check_eq("lol_st", {29'd0, lif.seq_st}, 1);
    check_eq("lol_ready", {31'd0, lif.lane_ready}, 0);
    check_eq("lol_pma", {31'd0, lif.lane_pma_rst}, 1);
    run_until("relock_done", 4, 100, n);
    lif.pll_lock = 1'b0; step(); lif.pll_lock = 1'b1;
    check_eq("pll_drop_st", {29'd0, lif.seq_st}, 0);

    // glitch at stable count 5 restarts the lock count
    run_until("g_wait", 2, 20, n);
    repeat (5) step();
    lif.cdr_lock = 1'b0; step(); lif.cdr_lock = 1'b1;
    run_until("g_pcs", 3, 100, n); check_eq("glitch_len", n, LOCK_STABLE_CYC);
    run_until("g_done", 4, 20, n);

    // stable-done on the timeout cycle wins over the timeout
    lif.cdr_lock = 1'b0;
    run_until("b_wait", 2, 20, n);
    repeat (TIMEOUT_CYC - LOCK_STABLE_CYC) step();
    lif.cdr_lock = 1'b1;
    repeat (LOCK_STABLE_CYC) step();
    check_eq("tie_st", {29'd0, lif.seq_st}, 3);
    check_eq("tie_retry", {29'd0, lif.retry_cnt}, 0);
    run_until("b_done", 4, 20, n);

    // timeout, retry, FAIL
    lif.cdr_lock = 1'b0;
    run_until("t_wait", 2, 20, n);
    run_until("t_retry", 1, 100, n); check_eq("timeout_len", n, TIMEOUT_CYC);
    check_eq("retry1", {29'd0, lif.retry_cnt}, 1);
    run_until("t_wait2", 2, 20, n);
    run_until("t_fail", 5, 100, n); check_eq("timeout2_len", n, TIMEOUT_CYC);
    check_eq("fail_terr", {31'd0, lif.timeout_err}, 1);
    check_eq("fail_rst", {30'd0, lif.lane_pma_rst, lif.lane_pcs_rst}, 3);
    check_eq("fail_retry", {29'd0, lif.retry_cnt}, MAX_RETRY);
    lif.pll_lock = 1'b0; repeat (3) step(); lif.pll_lock = 1'b1;
    step();
    check_eq("fail_hold", {29'd0, lif.seq_st}, 5);

    // soft reset recovery
    lif.soft_rst = 1'b1; step(); lif.soft_rst = 1'b0;
    check_eq("srst_st", {29'd0, lif.seq_st}, 0);
    check_eq("srst_retry", {29'd0, lif.retry_cnt}, 0);
    check_eq("srst_terr", {31'd0, lif.timeout_err}, 0);
    lif.cdr_lock = 1'b1;
    run_until("srst_done", 4, 100, n);

    // FAIL exit via lane_en toggle keeps timeout_err
    lif.cdr_lock = 1'b0;
    run_until("f2_fail", 5, 400, n);
    lif.lane_en = 1'b0; step();
    check_eq("en_low_st", {29'd0, lif.seq_st}, 0);
    check_eq("en_low_terr", {31'd0, lif.timeout_err}, 1);
    lif.lane_en = 1'b1; step();
    check_eq("en_high_st", {29'd0, lif.seq_st}, 1);

    // asynchronous reset mid WAIT_CDR
    run_until("a_wait", 2, 20, n);
    repeat (3) step();
    #2 rst_n = 1'b0;
    #1 check_eq("arst_outs", {22'd0, dut_outs()}, {22'd0, 10'b000_1_1_0_000_0});
    @(posedge clk); #1;
    check_eq("arst_hold", {22'd0, dut_outs()}, {22'd0, 10'b000_1_1_0_000_0});
    rst_n = 1'b1;
    model_reset();
    lif.cdr_lock = 1'b1;
    run_until("a_done", 4, 100, n);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
